gemm_tile_controller_nxn: RTL and testbench
===========================================

Name: gemm_tile_controller_nxn

Overview:
- Generalised tile sequencer for the multi-kernel GeMM datapath: walks M/N/K tile loops and generates A/B/C SRAM addresses, PE control codes and the C write strobe for NumKernels systolic arrays of NumLanes x NumLanes.
- Compared with the fixed 4x4 controller, it adds:
  - arbitrary (non-power-of-two) tile counts supplied directly;
  - parametrised flood/flush latencies;
  - C write backpressure (c_ready_i) with a PE hold code;
  - a busy/done handshake;
  - defined zero-dimension behaviour.
- Sits between the top-level CSRs and the kernel array; it has no datapath.

Parameters:
- NumLanes, 4, rows/cols per systolic array; C rows flushed per tile.
- NumKernels, 4, arrays sharing A; informational only (B/C word width is handled outside).
- SizeAddrWidth, 8, width of tile-count inputs and loop counters.
- AddrWidth, 16, SRAM address width.
- FloodCycles, 6, cycles spent in FLOOD after the last K element (2*NumLanes-2 for the current PE).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request; accepted only in IDLE
- m_tiles_i  in  SizeAddrWidth  number of M tiles (M/NumLanes); sampled at accepted start
- n_tiles_i  in  SizeAddrWidth  number of N tiles (N/(NumLanes*NumKernels)); sampled at start
- k_depth_i  in  SizeAddrWidth  K depth in elements; sampled at start
- c_ready_i  in  1  C write port can accept a word this cycle
- busy_o  out  1  high from CLEAR through DONE inclusive
- done_o  out  1  single-cycle pulse in DONE
- a_addr_o  out  AddrWidth  A read address
- b_addr_o  out  AddrWidth  B read address
- c_addr_o  out  AddrWidth  C write address
- fill_o  out  1  A/B read data valid; the datapath gates A/B to zero when low
- valid_data_o  out  1  PE valid
- pe_ctrl_o  out  2  PE code: 00 compute, 01 flush-shift, 10 hold, 11 clear
- c_we_o  out  1  C write strobe

Behaviour:
- **Reset values:** state IDLE, all counters 0, busy_o=0, done_o=0, fill_o=0, valid_data_o=0, c_we_o=0, pe_ctrl_o=11, all addresses 0. Reset mid-operation aborts to IDLE with no further writes.
- **Start:** start_i is sampled on the rising edge in IDLE and the sizes are latched into registers. start_i in any other state is ignored, and the latched sizes do not change.
- **Zero dimension:** if any latched size is 0, go IDLE -> DONE. This gives no reads and no writes; done_o pulses in the cycle after start.
- **States and outputs:**
  - IDLE: pe_ctrl=11.
  - CLEAR (1 cycle): pe_ctrl=11.
  - FILL (k_depth cycles): fill_o=1, valid_data=1, pe_ctrl=00, k_idx increments each cycle.
  - FLOOD (FloodCycles cycles): valid_data=1, pe_ctrl=00.
  - FLUSH (NumLanes accepted writes): see the FLUSH bullet.
  - DONE (1 cycle): done_o=1, pe_ctrl=11, then IDLE.
- **FLUSH:** with c_ready_i=1 the block drives c_we_o=1 and pe_ctrl=01, and the row counter r decrements from NumLanes-1. With c_ready_i=0 it drives c_we_o=0 and pe_ctrl=10, and r holds. Leave FLUSH after the write with r=0.
- **Loop order:** k inner, n middle, m outer.
  - m_idx/n_idx advance only on exit from FLUSH, so they stay constant for the whole tile and C addressing needs no shadow registers.
  - After FLUSH: if (m_idx,n_idx) is the last tile, go to DONE; otherwise go to CLEAR with k_idx=0.
- **Addresses:** modulo 2^AddrWidth, with products computed at AddrWidth.
  - a_addr = m_idx + k_idx*m_tiles
  - b_addr = n_idx + k_idx*n_tiles
  - c_addr = n_idx + (m_idx*NumLanes + r)*n_tiles
  - Outside FILL/FLUSH the addresses hold their last value. Their validity is qualified only by fill_o and c_we_o.
- **SRAM read model:** combinational read; data belongs to the same cycle as a_addr_o/b_addr_o.
- **Latency:** per tile, 1 + k_depth + FloodCycles + NumLanes + (stall cycles). With defaults, m=n=1 and k=4: start at edge 0, CLEAR cycle 1, FILL 2-5, FLOOD 6-11, FLUSH 12-15, done_o in cycle 16, busy_o high in cycles 1-16.
- **Count limits:** counts up to 2^SizeAddrWidth-1 are supported; a count of all ones must not wrap early.

Decomposition:
- Package gemm_ctrl_pkg:
  - pe_ctrl_e enum: PE_COMPUTE=2'b00, PE_FLUSH=2'b01, PE_HOLD=2'b10, PE_CLEAR=2'b11.
  - tile_state_e enum: IDLE, CLEAR, FILL, FLOOD, FLUSH, DONE.
- Sub-module gemm_tile_addr_gen: holds the m/n/k/r counters with tick/last signals and the address arithmetic. The top level keeps the FSM, the flood counter and the handshake.

Test Plan:
- **Single tile:** m=1, n=1, k=4, c_ready=1.
  - done_o in cycle 16 and busy_o high in cycles 1-16.
  - a_addr 0,1,2,3 during FILL; 4 writes at c_addr 3,2,1,0.
- **Non-power-of-two sizes:** m=3, n=2, k=5.
  - Exactly 24 writes.
  - Tile (2,1) writes c_addr 1+(8+r)*2 for r=3..0, i.e. 23,21,19,17.
  - b_addr at k=4 for n=1 is 9.
- **Backpressure:** default tile with c_ready low for 3 cycles at the second flush word.
  - pe_ctrl=10 and c_we=0 during the stall; r holds.
  - Same 4 addresses written; done delayed by 3 cycles (cycle 19).
- **Zero dimension:** k=0 start.
  - done_o in cycle 1 with no fill_o and no c_we_o.
  - A start_i pulse during busy (m=2 run) is ignored: the write count stays 8.
- **Reset:** rst_ni asserted mid-FLOOD.
  - All outputs return to reset values immediately (asynchronously).
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/gemm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gemm_ctrl_pkg: shared PE control codes and tile-sequencer state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gemm_ctrl_pkg;

  typedef enum logic [1:0] {
    PE_COMPUTE = 2'b00,
    PE_FLUSH   = 2'b01,
    PE_HOLD    = 2'b10,
    PE_CLEAR   = 2'b11
  } pe_ctrl_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    FLOOD = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } tile_state_e;

endpackage

`default_nettype wire

// File: rtl/gemm_tile_addr_gen.sv
// ---------------------------------------------------------------------------
// gemm_tile_addr_gen: m/n/k/row loop counters and A/B/C SRAM address arithmetic
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gemm_tile_addr_gen
  import gemm_ctrl_pkg::*;
#(
  parameter int NumLanes      = 4,
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [SizeAddrWidth-1:0] m_tiles_i,
  input  logic [SizeAddrWidth-1:0] n_tiles_i,
  input  logic [SizeAddrWidth-1:0] k_depth_i,
  input  logic                     tile_clr_i,
  input  logic                     k_clr_i,
  input  logic                     k_tick_i,
  input  logic                     r_load_i,
  input  logic                     r_tick_i,
  input  logic                     tile_tick_i,
  input  logic                     fill_en_i,
  input  logic                     flush_en_i,
  output logic                     k_last_o,
  output logic                     r_last_o,
  output logic                     tile_last_o,
  output logic [AddrWidth-1:0]     a_addr_o,
  output logic [AddrWidth-1:0]     b_addr_o,
  output logic [AddrWidth-1:0]     c_addr_o
);

  localparam int RW = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam logic [AddrWidth-1:0] LANES_A = AddrWidth'(NumLanes);

  logic [SizeAddrWidth-1:0] r_m_idx, r_n_idx, r_k_idx;
  logic [RW-1:0]            r_row;
  logic [AddrWidth-1:0]     r_a_hold, r_b_hold, r_c_hold;

  logic                 w_m_last, w_n_last;
  logic [AddrWidth-1:0] w_m, w_n, w_k, w_r, w_mt, w_nt;
  logic [AddrWidth-1:0] w_a, w_b, w_c;

  // Compare against count-1 so an all-ones count never wraps before its last step
  assign w_m_last    = (r_m_idx == m_tiles_i - SizeAddrWidth'(1));
  assign w_n_last    = (r_n_idx == n_tiles_i - SizeAddrWidth'(1));
  assign k_last_o    = (r_k_idx == k_depth_i - SizeAddrWidth'(1));
  assign r_last_o    = (r_row == '0);
  assign tile_last_o = w_m_last && w_n_last;

  assign w_m  = AddrWidth'(r_m_idx);
  assign w_n  = AddrWidth'(r_n_idx);
  assign w_k  = AddrWidth'(r_k_idx);
  assign w_r  = AddrWidth'(r_row);
  assign w_mt = AddrWidth'(m_tiles_i);
  assign w_nt = AddrWidth'(n_tiles_i);

  assign w_a = w_m + w_k * w_mt;
  assign w_b = w_n + w_k * w_nt;
  assign w_c = w_n + (w_m * LANES_A + w_r) * w_nt;

  assign a_addr_o = fill_en_i  ? w_a : r_a_hold;
  assign b_addr_o = fill_en_i  ? w_b : r_b_hold;
  assign c_addr_o = flush_en_i ? w_c : r_c_hold;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_idx  <= '0;
      r_n_idx  <= '0;
      r_k_idx  <= '0;
      r_row    <= '0;
      r_a_hold <= '0;
      r_b_hold <= '0;
      r_c_hold <= '0;
    end else begin
      if (tile_clr_i) begin
        r_m_idx <= '0;
        r_n_idx <= '0;
        r_k_idx <= '0;
      end else begin
        if (k_clr_i) begin
          r_k_idx <= '0;
        end else if (k_tick_i && !k_last_o) begin
          r_k_idx <= r_k_idx + SizeAddrWidth'(1);
        end
        // n is the middle loop, m the outer one
        if (tile_tick_i) begin
          if (w_n_last) begin
            r_n_idx <= '0;
            r_m_idx <= w_m_last ? '0 : r_m_idx + SizeAddrWidth'(1);
          end else begin
            r_n_idx <= r_n_idx + SizeAddrWidth'(1);
          end
        end
      end
      if (r_load_i) begin
        r_row <= RW'(NumLanes - 1);
      end else if (r_tick_i && !r_last_o) begin
        r_row <= r_row - RW'(1);
      end
      if (fill_en_i) begin
        r_a_hold <= w_a;
        r_b_hold <= w_b;
      end
      if (flush_en_i) begin
        r_c_hold <= w_c;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gemm_tile_controller_nxn.sv
// ---------------------------------------------------------------------------
// gemm_tile_controller_nxn: tile FSM, flood timing and busy/done handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gemm_tile_controller_nxn
  import gemm_ctrl_pkg::*;
#(
  parameter int NumLanes      = 4,
  parameter int NumKernels    = 4,
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16,
  parameter int FloodCycles   = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] m_tiles_i,
  input  logic [SizeAddrWidth-1:0] n_tiles_i,
  input  logic [SizeAddrWidth-1:0] k_depth_i,
  input  logic                     c_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AddrWidth-1:0]     a_addr_o,
  output logic [AddrWidth-1:0]     b_addr_o,
  output logic [AddrWidth-1:0]     c_addr_o,
  output logic                     fill_o,
  output logic                     valid_data_o,
  output logic [1:0]               pe_ctrl_o,
  output logic                     c_we_o
);

  localparam int FW = (FloodCycles > 1) ? $clog2(FloodCycles) : 1;
  localparam logic [FW-1:0] FLOOD_LAST = FW'((FloodCycles > 0) ? FloodCycles - 1 : 0);

  // NumKernels only sizes the B/C words outside this block
  if (NumKernels < 1) begin : g_no_kernels
  end

  tile_state_e              r_state;
  pe_ctrl_e                 r_pe_ctrl;
  logic                     r_busy, r_done, r_fill, r_valid;
  logic [FW-1:0]            r_flood_cnt;
  logic [SizeAddrWidth-1:0] r_m_tiles, r_n_tiles, r_k_depth;

  logic w_in_idle, w_in_flush, w_write, w_zero;
  logic w_k_last, w_r_last, w_tile_last;

  assign w_in_idle  = (r_state == IDLE);
  assign w_in_flush = (r_state == FLUSH);
  assign w_write    = w_in_flush && c_ready_i;
  assign w_zero     = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_depth_i == '0);

  gemm_tile_addr_gen #(
    .NumLanes      (NumLanes),
    .SizeAddrWidth (SizeAddrWidth),
    .AddrWidth     (AddrWidth)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_tiles_i   (r_m_tiles),
    .n_tiles_i   (r_n_tiles),
    .k_depth_i   (r_k_depth),
    .tile_clr_i  (w_in_idle && start_i),
    .k_clr_i     (r_state == CLEAR),
    .k_tick_i    (r_state == FILL),
    .r_load_i    (r_state == CLEAR),
    .r_tick_i    (w_write),
    .tile_tick_i (w_write && w_r_last),
    .fill_en_i   (r_state == FILL),
    .flush_en_i  (w_in_flush),
    .k_last_o    (w_k_last),
    .r_last_o    (w_r_last),
    .tile_last_o (w_tile_last),
    .a_addr_o    (a_addr_o),
    .b_addr_o    (b_addr_o),
    .c_addr_o    (c_addr_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_pe_ctrl   <= PE_CLEAR;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fill      <= 1'b0;
      r_valid     <= 1'b0;
      r_flood_cnt <= '0;
      r_m_tiles   <= '0;
      r_n_tiles   <= '0;
      r_k_depth   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_m_tiles <= m_tiles_i;
            r_n_tiles <= n_tiles_i;
            r_k_depth <= k_depth_i;
            r_busy    <= 1'b1;
            r_pe_ctrl <= PE_CLEAR;
            if (w_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          r_state   <= FILL;
          r_fill    <= 1'b1;
          r_valid   <= 1'b1;
          r_pe_ctrl <= PE_COMPUTE;
        end
        FILL: begin
          if (w_k_last) begin
            r_fill      <= 1'b0;
            r_flood_cnt <= '0;
            if (FloodCycles == 0) begin
              r_state   <= FLUSH;
              r_valid   <= 1'b0;
              r_pe_ctrl <= PE_HOLD;
            end else begin
              r_state <= FLOOD;
            end
          end
        end
        FLOOD: begin
          if (r_flood_cnt == FLOOD_LAST) begin
            r_state   <= FLUSH;
            r_valid   <= 1'b0;
            r_pe_ctrl <= PE_HOLD;
          end else begin
            r_flood_cnt <= r_flood_cnt + FW'(1);
          end
        end
        FLUSH: begin
          if (w_write && w_r_last) begin
            r_pe_ctrl <= PE_CLEAR;
            if (w_tile_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= CLEAR;
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_pe_ctrl <= PE_CLEAR;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_fill    <= 1'b0;
          r_valid   <= 1'b0;
          r_pe_ctrl <= PE_CLEAR;
        end
      endcase
    end
  end

  // The write strobe and flush/hold code follow c_ready_i within the same cycle
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign fill_o       = r_fill;
  assign valid_data_o = r_valid;
  assign c_we_o       = w_write;
  assign pe_ctrl_o    = w_in_flush ? (c_ready_i ? PE_FLUSH : PE_HOLD) : r_pe_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_controller_nxn.sv
// ---------------------------------------------------------------------------
// tb_gemm_tile_controller_nxn: cycle-timeline reference model bench for the tile controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gemm_tile_controller_nxn;

  localparam int LANES = 4;
  localparam int FLOOD = 6;
  localparam int MAXC  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        c_ready = 1'b1;
  logic [7:0]  m_t = '0, n_t = '0, k_d = '0;
  logic        busy_o, done_o, fill_o, valid_data_o, c_we_o;
  logic [15:0] a_addr_o, b_addr_o, c_addr_o;
  logic [1:0]  pe_ctrl_o;

  gemm_tile_controller_nxn dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .m_tiles_i    (m_t),
    .n_tiles_i    (n_t),
    .k_depth_i    (k_d),
    .c_ready_i    (c_ready),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .a_addr_o     (a_addr_o),
    .b_addr_o     (b_addr_o),
    .c_addr_o     (c_addr_o),
    .fill_o       (fill_o),
    .valid_data_o (valid_data_o),
    .pe_ctrl_o    (pe_ctrl_o),
    .c_we_o       (c_we_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        busy, done, fill, valid, we;
    bit [1:0]  pe;
    bit [15:0] a, b, c;
  } exp_t;

  typedef struct {
    int    m, n, k, mode;
    bit    extra;
    int    exp_w, exp_done;
    string name;
  } vec_t;

  exp_t        tl[MAXC];
  bit          rdy[MAXC];
  int          last_cyc;
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] wq[$], rq_a[$], rq_b[$];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_ctrl(input int c);
    return {tl[c].busy, tl[c].done, tl[c].fill, tl[c].valid, tl[c].we, tl[c].pe};
  endfunction

  // Cycle-by-cycle expectation laid out directly from the loop nest and phase lengths
  function automatic void build_model(input int m, input int n, input int k);
    int t = 1;
    int r;
    for (int i = 0; i < MAXC; i++) begin
      tl[i].busy = 0; tl[i].done = 0; tl[i].fill = 0; tl[i].valid = 0; tl[i].we = 0;
      tl[i].pe = 2'b11; tl[i].a = 0; tl[i].b = 0; tl[i].c = 0;
    end
    if (m == 0 || n == 0 || k == 0) begin
      tl[1].busy = 1; tl[1].done = 1; last_cyc = 1;
      return;
    end
    for (int mi = 0; mi < m; mi++) begin
      for (int ni = 0; ni < n; ni++) begin
        tl[t].busy = 1; t++;
        for (int ki = 0; ki < k; ki++) begin
          tl[t].busy = 1; tl[t].fill = 1; tl[t].valid = 1; tl[t].pe = 2'b00;
          tl[t].a = 16'(mi + ki * m);
          tl[t].b = 16'(ni + ki * n);
          t++;
        end
        for (int f = 0; f < FLOOD; f++) begin
          tl[t].busy = 1; tl[t].valid = 1; tl[t].pe = 2'b00; t++;
        end
        r = LANES - 1;
        while (r >= 0) begin
          tl[t].busy = 1;
          if (rdy[t]) begin
            tl[t].we = 1; tl[t].pe = 2'b01;
            tl[t].c = 16'(ni + (mi * LANES + r) * n);
            r--;
          end else begin
            tl[t].pe = 2'b10;
          end
          t++;
        end
      end
    end
    tl[t].busy = 1; tl[t].done = 1;
    last_cyc = t;
  endfunction

  task automatic run_op(input int m, input int n, input int k, input int mode, input bit extra,
                        output int nw, output int dcyc);
    string tag;
    tag = $sformatf("m%0d_n%0d_k%0d", m, n, k);
    for (int c = 0; c < MAXC; c++)
      rdy[c] = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 13 && c <= 15) : ($urandom_range(0, 9) < 7);
    build_model(m, n, k);
    wq.delete(); rq_a.delete(); rq_b.delete();
    nw = 0; dcyc = -1;
    @(negedge clk);
    m_t = 8'(m); n_t = 8'(n); k_d = 8'(k); start = 1'b1; c_ready = rdy[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= last_cyc + 1; cyc++) begin
      c_ready = rdy[cyc];
      if (extra && cyc == 5) begin start = 1'b1; m_t = 8'd3; n_t = 8'd3; k_d = 8'd1; end
      if (extra && cyc == 6) start = 1'b0;
      @(negedge clk);
      chk({"ctrl ", tag}, cyc, {25'd0, busy_o, done_o, fill_o, valid_data_o, c_we_o, pe_ctrl_o},
          {25'd0, exp_ctrl(cyc)});
      if (tl[cyc].fill) begin
        chk({"a_addr ", tag}, cyc, {16'd0, a_addr_o}, {16'd0, tl[cyc].a});
        chk({"b_addr ", tag}, cyc, {16'd0, b_addr_o}, {16'd0, tl[cyc].b});
      end
      if (tl[cyc].we) chk({"c_addr ", tag}, cyc, {16'd0, c_addr_o}, {16'd0, tl[cyc].c});
      if (c_we_o) begin nw++; wq.push_back(c_addr_o); end
      if (fill_o) begin rq_a.push_back(a_addr_o); rq_b.push_back(b_addr_o); end
      if (done_o && dcyc < 0) dcyc = cyc;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   nw, dcyc, m, n, k, exp_w;

    vecs[0] = '{1, 1, 4, 0, 1'b0, 4, 16, "single"};
    vecs[1] = '{3, 2, 5, 0, 1'b0, 24, 97, "npow2"};
    vecs[2] = '{1, 1, 4, 1, 1'b0, 4, 19, "stall"};
    vecs[3] = '{1, 1, 0, 0, 1'b0, 0, 1, "k_zero"};
    vecs[4] = '{2, 1, 4, 0, 1'b1, 8, 31, "start_busy"};
    vecs[5] = '{0, 2, 3, 0, 1'b0, 0, 1, "m_zero"};
    vecs[6] = '{1, 1, 255, 0, 1'b0, 4, 267, "k_max"};
    vecs[7] = '{255, 1, 1, 0, 1'b0, 1020, 3061, "m_max"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl", 0, {25'd0, busy_o, done_o, fill_o, valid_data_o, c_we_o, pe_ctrl_o}, 32'h03);
    chk("reset addr", 0, {a_addr_o, b_addr_o | c_addr_o}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].n, vecs[i].k, vecs[i].mode, vecs[i].extra, nw, dcyc);
      chk({"writes ", vecs[i].name}, i, nw, vecs[i].exp_w);
      chk({"done_cycle ", vecs[i].name}, i, dcyc, vecs[i].exp_done);
      if (i == 0 || i == 2) begin
        chk({"wseq ", vecs[i].name}, i, {wq[0][7:0], wq[1][7:0], wq[2][7:0], wq[3][7:0]}, 32'h03020100);
      end
      if (i == 0) chk("aseq single", i, {rq_a[0][7:0], rq_a[1][7:0], rq_a[2][7:0], rq_a[3][7:0]}, 32'h00010203);
      if (i == 1) begin
        chk("last tile c", i, {wq[20][7:0], wq[21][7:0], wq[22][7:0], wq[23][7:0]},
            {8'd23, 8'd21, 8'd19, 8'd17});
        chk("b_addr n1 k4", i, {16'd0, rq_b[9]}, 32'd9);
      end
    end

    for (int i = 0; i < 8; i++) begin
      m = $urandom_range(0, 3); n = $urandom_range(1, 3); k = $urandom_range(0, 6);
      exp_w = (m > 0 && k > 0) ? m * n * LANES : 0;
      run_op(m, n, k, 2, 1'b0, nw, dcyc);
      chk("rand writes", i, nw, exp_w);
      chk("rand done_cycle", i, dcyc, last_cyc);
    end

    // Asynchronous reset in the middle of FLOOD, then a clean rerun
    @(negedge clk);
    m_t = 8'd1; n_t = 8'd1; k_d = 8'd4; start = 1'b1; c_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("pre-reset flood", 9, {29'd0, busy_o, valid_data_o, fill_o}, 32'h6);
    rst_n = 1'b0;
    #1;
    chk("async reset ctrl", 9, {25'd0, busy_o, done_o, fill_o, valid_data_o, c_we_o, pe_ctrl_o}, 32'h03);
    chk("async reset addr", 9, {a_addr_o, b_addr_o | c_addr_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 1, 4, 0, 1'b0, nw, dcyc);
    chk("post-reset writes", 0, nw, 4);
    chk("post-reset done_cycle", 0, dcyc, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
